// File: rtl/unidade_controle_sequenciador_pkg.sv
// Shared state codes for the memory-game control unit; also used by the
// datapath debug decoder and the benches.
package unidade_controle_sequenciador_pkg;

  localparam int EST_W = 5;

  localparam logic [EST_W-1:0] INICIAL           = 5'h00;
  localparam logic [EST_W-1:0] PREPARACAO        = 5'h01;
  localparam logic [EST_W-1:0] INICIA_RODADA     = 5'h02;
  localparam logic [EST_W-1:0] MOSTRA_LED        = 5'h03;
  localparam logic [EST_W-1:0] APAGA_LED         = 5'h04;
  localparam logic [EST_W-1:0] PROXIMO_LED       = 5'h05;
  localparam logic [EST_W-1:0] PROXIMA_SEQUENCIA = 5'h07;
  localparam logic [EST_W-1:0] INICIO_JOGADA     = 5'h09;
  localparam logic [EST_W-1:0] ESPERA_JOGADA     = 5'h0A;
  localparam logic [EST_W-1:0] REGISTRA          = 5'h0B;
  localparam logic [EST_W-1:0] COMPARACAO        = 5'h0C;
  localparam logic [EST_W-1:0] PROXIMA_JOGADA    = 5'h0D;
  localparam logic [EST_W-1:0] FINAL_ACERTOU     = 5'h0E;
  localparam logic [EST_W-1:0] FINAL_ERROU       = 5'h0F;
  localparam logic [EST_W-1:0] FINAL_TIMEOUT     = 5'h10;

endpackage

// File: rtl/unidade_controle_sequenciador.sv
// Moore FSM sequencing the memory-game datapath: replay, collect, compare.
// Optional macro TIMEOUT_EN enables the play-wait timeout ending.
module unidade_controle_sequenciador
  import unidade_controle_sequenciador_pkg::*;
#(
  parameter int ESTADO_W = EST_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                jogada_feita,
  input  logic                igual_jogada,
  input  logic                fim_jogada,
  input  logic                fim_seq,
  input  logic                fim_tempo_led,
  input  logic                timeout,
  output logic                zera_e,
  output logic                conta_e,
  output logic                zera_l,
  output logic                conta_l,
  output logic                zera_r,
  output logic                registra_r,
  output logic                zera_t,
  output logic                conta_t,
  output logic                leds_en,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  logic [ESTADO_W-1:0] r_estado;
  logic [ESTADO_W-1:0] w_proximo;

`ifndef TIMEOUT_EN
  logic w_unused_timeout;
  assign w_unused_timeout = timeout;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_proximo;
  end

  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:           w_proximo = jogar ? PREPARACAO : INICIAL;
      PREPARACAO:        w_proximo = INICIA_RODADA;
      INICIA_RODADA:     w_proximo = MOSTRA_LED;
      MOSTRA_LED:        w_proximo = fim_tempo_led ? APAGA_LED : MOSTRA_LED;
      APAGA_LED: begin
        if (!fim_tempo_led)  w_proximo = APAGA_LED;
        else if (fim_jogada) w_proximo = INICIO_JOGADA;
        else                 w_proximo = PROXIMO_LED;
      end
      PROXIMO_LED:       w_proximo = MOSTRA_LED;
      INICIO_JOGADA:     w_proximo = ESPERA_JOGADA;
      // A button press in the same cycle as timeout still counts as a play.
      ESPERA_JOGADA: begin
        if (jogada_feita) w_proximo = REGISTRA;
`ifdef TIMEOUT_EN
        else if (timeout) w_proximo = FINAL_TIMEOUT;
`endif
        else              w_proximo = ESPERA_JOGADA;
      end
      REGISTRA:          w_proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual_jogada)   w_proximo = FINAL_ERROU;
        else if (!fim_jogada) w_proximo = PROXIMA_JOGADA;
        else if (fim_seq)    w_proximo = FINAL_ACERTOU;
        else                 w_proximo = PROXIMA_SEQUENCIA;
      end
      PROXIMA_JOGADA:    w_proximo = ESPERA_JOGADA;
      PROXIMA_SEQUENCIA: w_proximo = INICIA_RODADA;
      FINAL_ACERTOU:     w_proximo = jogar ? PREPARACAO : FINAL_ACERTOU;
      FINAL_ERROU:       w_proximo = jogar ? PREPARACAO : FINAL_ERROU;
`ifdef TIMEOUT_EN
      FINAL_TIMEOUT:     w_proximo = jogar ? PREPARACAO : FINAL_TIMEOUT;
`endif
      default:           w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    zera_e     = 1'b0;
    conta_e    = 1'b0;
    zera_l     = 1'b0;
    conta_l    = 1'b0;
    zera_r     = 1'b0;
    registra_r = 1'b0;
    zera_t     = 1'b0;
    conta_t    = 1'b0;
    leds_en    = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (r_estado)
      PREPARACAO: begin
        zera_l = 1'b1;
        zera_r = 1'b1;
        zera_e = 1'b1;
        zera_t = 1'b1;
      end
      INICIA_RODADA: begin
        zera_e = 1'b1;
        zera_t = 1'b1;
      end
      MOSTRA_LED: begin
        leds_en = 1'b1;
        conta_t = 1'b1;
      end
      APAGA_LED:         conta_t = 1'b1;
      PROXIMO_LED: begin
        conta_e = 1'b1;
        zera_t  = 1'b1;
      end
      INICIO_JOGADA: begin
        zera_e = 1'b1;
        zera_t = 1'b1;
        zera_r = 1'b1;
      end
      ESPERA_JOGADA:     conta_t = 1'b1;
      REGISTRA:          registra_r = 1'b1;
      PROXIMA_JOGADA: begin
        conta_e = 1'b1;
        zera_t  = 1'b1;
      end
      PROXIMA_SEQUENCIA: conta_l = 1'b1;
      FINAL_ACERTOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FINAL_ERROU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
`ifdef TIMEOUT_EN
      FINAL_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule
